riscv_axi_loader: RTL and testbench

- AXI4 write-only master that loads program/data images into a RISC-V core's AXI slave memory window and drives the core reset register.
- Sits between the host/scheduler command logic and one core wrapper's s_axi write channels.
- Converts a command (start address, beat count) plus a data stream into 4KB-safe INCR bursts.
- Also issues single-beat writes to the core-reset register to hold the core in reset or release it.

---
 rtl/riscv_axi_loader.sv | 182 ++++++++++++++++++
 tb/tb_riscv_axi_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_axi_loader.sv
// riscv_axi_loader
//   AXI4 write-only master that loads program/data images into a RISC-V
//   core's AXI slave window and drives the core reset register.
//   A command (start address, beat count) plus a data stream is split into
//   INCR bursts that never exceed MAX_BURST beats and never cross a 4KB page.
//   Ops 10/11 issue a single-beat write to the core-reset register (top word
//   of the address space) to hold/release the core.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cmd_*             command handshake: op, byte address, beat count
//   in_*              load data stream (valid/ready), passed through to W
//   busy, done        command in progress / one-cycle completion pulse
//   error             sticky write-response error flag
//   m_axi_aw*/w*/b*   AXI4 write address/data/response channels
//
// Build option:
//   RISCV_AXI_LOADER_RESP_CHECK_EN  when defined, any B response with
//   bresp != OKAY sets the sticky error flag; otherwise error is tied low.

module riscv_axi_loader #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_beats,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [STRB_WIDTH-1:0] in_strb,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int unsigned LSB        = $clog2(STRB_WIDTH);
  localparam int unsigned PAGE_BEATS = 4096 >> LSB;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;       // aligned address of the next burst
  logic [15:0]           remaining;  // beats not yet accepted on W
  logic [8:0]            blen;       // length of the burst in flight
  logic [8:0]            beat_cnt;   // beats already sent in this burst
  logic                  rst_op;     // current command is a core-reset write
  logic                  rst_val;    // bit0 value for the core-reset write

  logic [12:0]           to_page;
  logic [16:0]           len_calc;
  logic [8:0]            cur_len;
  logic [ADDR_WIDTH-1:0] addr_step;
  logic                  last_beat;
  logic                  w_hs;

  // Burst length = min(remaining, MAX_BURST, beats left in the 4KB page).
  always_comb begin
    to_page  = 13'(PAGE_BEATS) - 13'(addr[11:LSB]);
    len_calc = {1'b0, remaining};
    if (len_calc > 17'(MAX_BURST)) len_calc = 17'(MAX_BURST);
    if (len_calc > 17'(to_page))   len_calc = 17'(to_page);
    cur_len  = len_calc[8:0];
  end

  assign addr_step = ADDR_WIDTH'(blen) << LSB;
  assign last_beat = (beat_cnt == blen - 9'd1);
  assign w_hs      = m_axi_wvalid && m_axi_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      blen      <= '0;
      beat_cnt  <= '0;
      rst_op    <= 1'b0;
      rst_val   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          rst_op  <= cmd_op[1];
          rst_val <= ~cmd_op[0];
          if (cmd_op[1]) begin
            // Core-reset register: top aligned word, reached as a 1-beat burst.
            addr      <= ALIGN_MASK;
            remaining <= 16'd1;
            state     <= S_AW;
          end else begin
            addr      <= cmd_addr & ALIGN_MASK;
            remaining <= cmd_beats;
            state     <= (cmd_beats == 16'd0) ? S_FIN : S_AW;
          end
        end
        S_AW: if (m_axi_awready) begin
          blen     <= cur_len;
          beat_cnt <= '0;
          state    <= S_W;
        end
        S_W: if (w_hs) begin
          remaining <= remaining - 16'd1;
          beat_cnt  <= beat_cnt + 9'd1;
          if (last_beat) state <= S_B;
        end
        S_B: if (m_axi_bvalid) begin
          addr  <= addr + addr_step;
          state <= (remaining == 16'd0) ? S_FIN : S_AW;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RISCV_AXI_LOADER_RESP_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (state == S_B && m_axi_bvalid && m_axi_bresp != 2'b00)
      err_q <= 1'b1;
  end
  assign error = err_q;
  logic unused_inputs;
  assign unused_inputs = ^m_axi_bid;
`else
  assign error = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_bresp};
`endif

  assign cmd_ready     = (state == S_IDLE) && !rst;
  assign busy          = (state == S_AW) || (state == S_W) || (state == S_B);
  assign done          = (state == S_FIN);

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = 8'(cur_len - 9'd1);
  assign m_axi_awsize  = 3'(LSB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state == S_AW);

  // W channel is a combinational pass-through of the load stream; reset-op
  // writes source their own beat and keep the stream stalled.
  assign m_axi_wvalid  = (state == S_W) && (rst_op || in_valid);
  assign in_ready      = (state == S_W) && !rst_op && m_axi_wready;
  assign m_axi_wdata   = rst_op ? DATA_WIDTH'(rst_val) : in_data;
  assign m_axi_wstrb   = rst_op ? '1 : in_strb;
  assign m_axi_wlast   = (state == S_W) && last_beat;

  assign m_axi_bready  = (state == S_B);

endmodule

// File: tb/tb_riscv_axi_loader.sv
// Directed testbench for riscv_axi_loader (64-bit data, 16-bit address,
// MAX_BURST 16). A negedge-driven AXI slave / stream source model records
// every AW and W handshake; the main initial block runs directed commands
// and compares the records against hand-computed values.
module tb_riscv_axi_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_beats = '0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_strb = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        busy, done, error;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [7:0]  m_axi_bid = '0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

`ifdef RISCV_AXI_LOADER_RESP_CHECK_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  riscv_axi_loader #(
    .DATA_WIDTH(64), .ADDR_WIDTH(16), .ID_WIDTH(8), .AXI_ID(0), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .in_data(in_data), .in_strb(in_strb), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .error(error),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i, input int s);
    return {16'(s), 16'hBEEF, 16'(i), 16'(i * 7)};
  endfunction

  function automatic logic [7:0] spat(input int i);
    return 8'hFF ^ 8'(i * 3);
  endfunction

  // Slave / source model state
  bit          stall = 1'b0;
  bit          hold_w = 1'b0;
  int          bad_burst = -1;
  logic [63:0] src_data [64];
  logic [7:0]  src_strb [64];
  int          src_n = 0, src_idx = 0;
  logic [15:0] awa_q [$];
  logic [7:0]  awl_q [$];
  logic [63:0] wd_q [$];
  logic [7:0]  ws_q [$];
  bit          wl_q [$];
  int          bursts_b = 0;
  bit          b_pending = 1'b0, aw_open = 1'b0, aw_hold = 1'b0, in_ready_seen = 1'b0;
  logic [15:0] held_addr;
  logic [7:0]  held_len;

  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; in_valid = 1'b0;
      b_pending = 1'b0; aw_open = 1'b0; aw_hold = 1'b0;
    end else begin
      m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = hold_w ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      in_valid      = (src_idx < src_n) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      if (src_idx < src_n && src_idx < 64) begin
        in_data = src_data[src_idx];
        in_strb = src_strb[src_idx];
      end
      m_axi_bvalid  = b_pending && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axi_bresp   = (bursts_b == bad_burst) ? 2'b10 : 2'b00;
      #1;
      if (aw_hold) begin
        chk("aw_hold_valid", m_axi_awvalid, 1'b1);
        chk("aw_hold_addr", m_axi_awaddr, held_addr);
        chk("aw_hold_len", m_axi_awlen, held_len);
      end
      aw_hold = 1'b0;
      if (m_axi_awvalid) begin
        if (m_axi_awready) begin
          awa_q.push_back(m_axi_awaddr);
          awl_q.push_back(m_axi_awlen);
          chk("aw_const", {m_axi_awid, 5'd0, m_axi_awsize, 6'd0, m_axi_awburst}, {8'd0, 5'd0, 3'd3, 6'd0, 2'b01});
          aw_open = 1'b1;
        end else begin
          aw_hold = 1'b1; held_addr = m_axi_awaddr; held_len = m_axi_awlen;
        end
      end
      if (m_axi_wvalid) chk("w_after_aw", aw_open, 1'b1);
      if (in_ready) in_ready_seen = 1'b1;
      if (m_axi_wvalid && m_axi_wready) begin
        wd_q.push_back(m_axi_wdata);
        ws_q.push_back(m_axi_wstrb);
        wl_q.push_back(m_axi_wlast);
        if (m_axi_wlast) begin b_pending = 1'b1; aw_open = 1'b0; end
      end
      if (in_valid && in_ready) src_idx++;
      if (m_axi_bvalid && m_axi_bready) begin b_pending = 1'b0; bursts_b++; end
    end
  end

  task automatic clear_rec();
    awa_q.delete(); awl_q.delete(); wd_q.delete(); ws_q.delete(); wl_q.delete();
    bursts_b = 0; in_ready_seen = 1'b0;
  endtask

  task automatic load_src(input int n, input int s);
    for (int i = 0; i < 64; i++) begin
      src_data[i] = pat(i, s);
      src_strb[i] = spat(i);
    end
    src_n = n; src_idx = 0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
    bit got;
    got = 1'b0; lat = -1;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_beats = b; cmd_valid = 1'b1;
    #2 chk("cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 3000 && !got; c++) begin
      #2;
      if (done) begin got = 1'b1; lat = c; end
      else @(negedge clk);
    end
    chk("cmd_done_seen", got, 1'b1);
    @(negedge clk);
    #2;
    chk("done_one_cycle", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int lat;
    bit seen;

    // Reset values
    #3;
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Load 4 beats at 0x8000 (IMEM)
    clear_rec(); load_src(4, 1);
    run_cmd(2'b00, 16'h8000, 16'd4, lat);
    chk("t1_aw_count", awa_q.size(), 1);
    chk("t1_awaddr", awa_q[0], 16'h8000);
    chk("t1_awlen", awl_q[0], 8'd3);
    chk("t1_w_count", wd_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_wdata", wd_q[i], pat(i, 1));
      chk("t1_wstrb", ws_q[i], spat(i));
      chk("t1_wlast", wl_q[i], (i == 3));
    end

    // Single beat with reserved op 01 (behaves as load): minimum latency
    clear_rec(); load_src(1, 2);
    run_cmd(2'b01, 16'h0008, 16'd1, lat);
    chk("t1b_latency", lat, 4);
    chk("t1b_awaddr", awa_q[0], 16'h0008);
    chk("t1b_awlen", awl_q[0], 8'd0);
    chk("t1b_wdata", wd_q[0], pat(0, 2));

    // 8 beats at 0x0FF0: split at 4KB boundary
    clear_rec(); load_src(8, 3);
    run_cmd(2'b00, 16'h0FF0, 16'd8, lat);
    chk("t2_aw_count", awa_q.size(), 2);
    chk("t2_awaddr0", awa_q[0], 16'h0FF0);
    chk("t2_awlen0", awl_q[0], 8'd1);
    chk("t2_awaddr1", awa_q[1], 16'h1000);
    chk("t2_awlen1", awl_q[1], 8'd5);
    chk("t2_w_count", wd_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_wdata", wd_q[i], pat(i, 3));
      chk("t2_wlast", wl_q[i], (i == 1 || i == 7));
    end

    // Release core reset (11) then assert core reset (10)
    clear_rec(); load_src(0, 4);
    run_cmd(2'b11, 16'h1234, 16'd9, lat);
    chk("rel_latency", lat, 4);
    chk("rel_aw_count", awa_q.size(), 1);
    chk("rel_awaddr", awa_q[0], 16'hFFF8);
    chk("rel_awlen", awl_q[0], 8'd0);
    chk("rel_wdata", wd_q[0], 64'd0);
    chk("rel_wstrb", ws_q[0], 8'hFF);
    chk("rel_wlast", wl_q[0], 1'b1);
    chk("rel_in_ready", in_ready_seen, 1'b0);
    clear_rec();
    run_cmd(2'b10, 16'h0000, 16'd0, lat);
    chk("hold_awaddr", awa_q[0], 16'hFFF8);
    chk("hold_awlen", awl_q[0], 8'd0);
    chk("hold_wdata", wd_q[0], 64'd1);
    chk("hold_wstrb", ws_q[0], 8'hFF);
    chk("hold_in_ready", in_ready_seen, 1'b0);

    // Zero-beat load
    clear_rec(); load_src(0, 5);
    run_cmd(2'b00, 16'h0400, 16'd0, lat);
    chk("zero_latency", lat, 1);
    chk("zero_aw_count", awa_q.size(), 0);
    chk("zero_w_count", wd_q.size(), 0);
    chk("pre_error", error, 1'b0);

    // 40 beats with random stalls, SLVERR on burst 2 of 3
    clear_rec(); load_src(40, 6);
    stall = 1'b1; bad_burst = 1;
    run_cmd(2'b00, 16'h0100, 16'd40, lat);
    stall = 1'b0; bad_burst = -1;
    chk("t3_aw_count", awa_q.size(), 3);
    chk("t3_awaddr0", awa_q[0], 16'h0100);
    chk("t3_awaddr1", awa_q[1], 16'h0180);
    chk("t3_awaddr2", awa_q[2], 16'h0200);
    chk("t3_awlen0", awl_q[0], 8'd15);
    chk("t3_awlen1", awl_q[1], 8'd15);
    chk("t3_awlen2", awl_q[2], 8'd7);
    chk("t3_w_count", wd_q.size(), 40);
    chk("t3_b_count", bursts_b, 3);
    for (int i = 0; i < 40; i++) begin
      chk("t3_wdata", wd_q[i], pat(i, 6));
      chk("t3_wstrb", ws_q[i], spat(i));
      chk("t3_wlast", wl_q[i], (i == 15 || i == 31 || i == 39));
    end
    chk("t3_error", error, ERR_EXP);

    // Asynchronous reset in the middle of the W phase
    clear_rec(); load_src(8, 7); hold_w = 1'b1;
    @(negedge clk);
    cmd_op = 2'b00; cmd_addr = 16'h0040; cmd_beats = 16'd8; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      #2;
      if (m_axi_wvalid) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rstw_reach_w", seen, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstw_awvalid", m_axi_awvalid, 1'b0);
    chk("rstw_wvalid", m_axi_wvalid, 1'b0);
    chk("rstw_bready", m_axi_bready, 1'b0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_done", done, 1'b0);
    chk("rstw_cmd_ready", cmd_ready, 1'b0);
    chk("rstw_in_ready", in_ready, 1'b0);
    chk("rstw_error", error, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; hold_w = 1'b0;

    // Normal command after reset; low address bits ignored
    clear_rec(); load_src(1, 8);
    run_cmd(2'b00, 16'h123B, 16'd1, lat);
    chk("post_latency", lat, 4);
    chk("post_awaddr", awa_q[0], 16'h1238);
    chk("post_awlen", awl_q[0], 8'd0);
    chk("post_wdata", wd_q[0], pat(0, 8));
    chk("post_wlast", wl_q[0], 1'b1);
    chk("post_error", error, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
